// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types for the I2S FIFO write arbiter.
// Provides the channel enum and the tag-bit position helper.
package i2s_pkg;

    // Channel identity; also the tag value written into the FIFO MSB.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    // The channel tag sits directly above the sample bits.
    function automatic int tag_bit(input int sample_width);
        return sample_width;
    endfunction

endpackage

// File: rtl/i2s_sample_slot.sv
// i2s_sample_slot: one-entry holding slot for one I2S channel.
// Ports: clk, rst_n, capture_i/data_i (new sample), take_i (slot written
// to FIFO), clear_i (drop counter clear), pending_o, data_o, drop_cnt_o.
// Drop counter only exists when I2S_ARB_DROP_CNT_EN is defined.
module i2s_sample_slot
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 24,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      capture_i,
    input  logic [SAMPLE_WIDTH-1:0]   data_i,
    input  logic                      take_i,
    input  logic                      clear_i,
    output logic                      pending_o,
    output logic [SAMPLE_WIDTH-1:0]   data_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    logic                    r_pending;
    logic [SAMPLE_WIDTH-1:0] r_data;

    // A capture wins over a take: the old word leaves, the new one stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_data    <= '0;
        end else begin
            if (capture_i) begin
                r_pending <= 1'b1;
                r_data    <= data_i;
            end else if (take_i) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign pending_o = r_pending;
    assign data_o    = r_data;

`ifdef I2S_ARB_DROP_CNT_EN
    logic                      w_drop;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    // Overwriting a sample that is not leaving this cycle loses it.
    assign w_drop = capture_i & r_pending & ~take_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    logic w_unused_clear;

    assign w_unused_clear = clear_i;
    assign drop_cnt_o     = '0;
`endif

endmodule

// File: rtl/i2s_fifo_write_arbiter.sv
// i2s_fifo_write_arbiter: round-robin sharing of one FIFO write port
// between the left and right I2S capture paths.
// Ports: clk, rst_n, enable_i, left/right valid+data, fifo_full_i,
// fifo_wr_en_o, fifo_write_data_o ({tag, sample}), clear_drop_i,
// left/right_drop_cnt_o, busy_o. Optional macro: I2S_ARB_DROP_CNT_EN.
module i2s_fifo_write_arbiter
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 24,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic                      left_valid_i,
    input  logic [SAMPLE_WIDTH-1:0]   left_data_i,
    input  logic                      right_valid_i,
    input  logic [SAMPLE_WIDTH-1:0]   right_data_i,
    input  logic                      fifo_full_i,
    output logic                      fifo_wr_en_o,
    output logic [SAMPLE_WIDTH:0]     fifo_write_data_o,
    input  logic                      clear_drop_i,
    output logic [DROP_CNT_WIDTH-1:0] left_drop_cnt_o,
    output logic [DROP_CNT_WIDTH-1:0] right_drop_cnt_o,
    output logic                      busy_o
);

    localparam int TAG_BIT = tag_bit(SAMPLE_WIDTH);

    logic                    w_left_pending;
    logic                    w_right_pending;
    logic [SAMPLE_WIDTH-1:0] w_left_data;
    logic [SAMPLE_WIDTH-1:0] w_right_data;
    logic                    w_wr_en;
    ch_e                     w_grant;
    ch_e                     r_last_grant;
    logic [SAMPLE_WIDTH:0]   w_wdata;

    i2s_sample_slot #(
        .SAMPLE_WIDTH   (SAMPLE_WIDTH),
        .DROP_CNT_WIDTH (DROP_CNT_WIDTH)
    ) u_left (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_i  (left_valid_i & enable_i),
        .data_i     (left_data_i),
        .take_i     (w_wr_en & (w_grant == CH_LEFT)),
        .clear_i    (clear_drop_i),
        .pending_o  (w_left_pending),
        .data_o     (w_left_data),
        .drop_cnt_o (left_drop_cnt_o)
    );

    i2s_sample_slot #(
        .SAMPLE_WIDTH   (SAMPLE_WIDTH),
        .DROP_CNT_WIDTH (DROP_CNT_WIDTH)
    ) u_right (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_i  (right_valid_i & enable_i),
        .data_i     (right_data_i),
        .take_i     (w_wr_en & (w_grant == CH_RIGHT)),
        .clear_i    (clear_drop_i),
        .pending_o  (w_right_pending),
        .data_o     (w_right_data),
        .drop_cnt_o (right_drop_cnt_o)
    );

    assign w_wr_en = (w_left_pending | w_right_pending) & ~fifo_full_i;

    // On a tie, serve whichever channel was not served last.
    always_comb begin
        w_grant = CH_LEFT;
        if (w_left_pending && w_right_pending) begin
            w_grant = (r_last_grant == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end else if (w_right_pending) begin
            w_grant = CH_RIGHT;
        end
    end

    // Reset value CH_RIGHT makes left win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= CH_RIGHT;
        end else if (w_wr_en) begin
            r_last_grant <= w_grant;
        end
    end

    always_comb begin
        w_wdata = '0;
        if (w_wr_en) begin
            w_wdata[TAG_BIT] = w_grant;
            w_wdata[TAG_BIT-1:0] = (w_grant == CH_RIGHT) ? w_right_data
                                                         : w_left_data;
        end
    end

    assign fifo_wr_en_o      = w_wr_en;
    assign fifo_write_data_o = w_wdata;
    assign busy_o            = w_left_pending | w_right_pending;

endmodule

// File: tb/tb_i2s_fifo_write_arbiter.sv
// tb_i2s_fifo_write_arbiter: directed vector table plus hand-written
// reset sequence for i2s_fifo_write_arbiter (2-bit drop counters).
module tb_i2s_fifo_write_arbiter;

    localparam int SW = 24;
    localparam int CW = 2;

`ifdef I2S_ARB_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic          en;
        logic          lv;
        logic [SW-1:0] ld;
        logic          rv;
        logic [SW-1:0] rd;
        logic          full;
        logic          clr;
        logic          wr;
        logic [SW:0]   data;
        logic          busy;
        logic [CW-1:0] lc;
        logic [CW-1:0] rc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          left_valid_i;
    logic [SW-1:0] left_data_i;
    logic          right_valid_i;
    logic [SW-1:0] right_data_i;
    logic          fifo_full_i;
    logic          fifo_wr_en_o;
    logic [SW:0]   fifo_write_data_o;
    logic          clear_drop_i;
    logic [CW-1:0] left_drop_cnt_o;
    logic [CW-1:0] right_drop_cnt_o;
    logic          busy_o;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[36];

    i2s_fifo_write_arbiter #(
        .SAMPLE_WIDTH   (SW),
        .DROP_CNT_WIDTH (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable_i          (enable_i),
        .left_valid_i      (left_valid_i),
        .left_data_i       (left_data_i),
        .right_valid_i     (right_valid_i),
        .right_data_i      (right_data_i),
        .fifo_full_i       (fifo_full_i),
        .fifo_wr_en_o      (fifo_wr_en_o),
        .fifo_write_data_o (fifo_write_data_o),
        .clear_drop_i      (clear_drop_i),
        .left_drop_cnt_o   (left_drop_cnt_o),
        .right_drop_cnt_o  (right_drop_cnt_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ce(input logic [CW-1:0] v);
        return CNT_EN ? v : '0;
    endfunction

    task automatic drive(input logic en, input logic lv,
                         input logic [SW-1:0] ld, input logic rv,
                         input logic [SW-1:0] rd, input logic full,
                         input logic clr);
        enable_i      = en;
        left_valid_i  = lv;
        left_data_i   = ld;
        right_valid_i = rv;
        right_data_i  = rd;
        fifo_full_i   = full;
        clear_drop_i  = clr;
    endtask

    task automatic check(input string name, input logic wr,
                         input logic [SW:0] data, input logic busy,
                         input logic [CW-1:0] lc, input logic [CW-1:0] rc);
        logic [SW+2+2*CW:0] got;
        logic [SW+2+2*CW:0] exp;
        got = {fifo_wr_en_o, fifo_write_data_o, busy_o,
               left_drop_cnt_o, right_drop_cnt_o};
        exp = {wr, data, busy, ce(lc), ce(rc)};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got wr=%b data=%h busy=%b lc=%0d rc=%0d, want wr=%b data=%h busy=%b lc=%0d rc=%0d",
                     name, fifo_wr_en_o, fifo_write_data_o, busy_o,
                     left_drop_cnt_o, right_drop_cnt_o,
                     wr, data, busy, ce(lc), ce(rc));
        end
    endtask

    initial begin
        // en lv ld rv rd full clr | wr data busy lc rc
        vecs[0]  = '{1,0,24'h0,0,24'h0,0,0, 0,25'h0,0,0,0};
        vecs[1]  = '{1,1,24'h000001,1,24'h000002,0,0, 0,25'h0,0,0,0};
        vecs[2]  = '{1,0,24'h0,0,24'h0,0,0, 1,25'h0000001,1,0,0};
        vecs[3]  = '{1,0,24'h0,0,24'h0,0,0, 1,25'h1000002,1,0,0};
        vecs[4]  = '{1,0,24'h0,0,24'h0,0,0, 0,25'h0,0,0,0};
        vecs[5]  = '{1,1,24'h123456,0,24'h0,0,0, 0,25'h0,0,0,0};
        vecs[6]  = '{1,0,24'h0,0,24'h0,0,0, 1,25'h0123456,1,0,0};
        vecs[7]  = '{1,0,24'h0,0,24'h0,0,0, 0,25'h0,0,0,0};
        vecs[8]  = '{1,1,24'h00000A,0,24'h0,1,0, 0,25'h0,0,0,0};
        vecs[9]  = '{1,1,24'h00000B,0,24'h0,1,0, 0,25'h0,1,0,0};
        vecs[10] = '{1,1,24'h00000C,0,24'h0,1,0, 0,25'h0,1,1,0};
        vecs[11] = '{1,0,24'h0,0,24'h0,1,0, 0,25'h0,1,2,0};
        vecs[12] = '{1,0,24'h0,0,24'h0,0,0, 1,25'h000000C,1,2,0};
        vecs[13] = '{1,0,24'h0,0,24'h0,0,0, 0,25'h0,0,2,0};
        vecs[14] = '{1,1,24'h111111,0,24'h0,0,0, 0,25'h0,0,2,0};
        vecs[15] = '{1,1,24'h222222,0,24'h0,0,0, 1,25'h0111111,1,2,0};
        vecs[16] = '{1,0,24'h0,0,24'h0,0,0, 1,25'h0222222,1,2,0};
        vecs[17] = '{1,0,24'h0,0,24'h0,0,0, 0,25'h0,0,2,0};
        vecs[18] = '{1,1,24'h000001,0,24'h0,1,0, 0,25'h0,0,2,0};
        vecs[19] = '{1,1,24'h000002,0,24'h0,1,0, 0,25'h0,1,2,0};
        vecs[20] = '{1,1,24'h000003,0,24'h0,1,0, 0,25'h0,1,3,0};
        vecs[21] = '{1,1,24'h000004,0,24'h0,1,0, 0,25'h0,1,3,0};
        vecs[22] = '{1,1,24'h000005,0,24'h0,1,0, 0,25'h0,1,3,0};
        vecs[23] = '{1,1,24'h000006,0,24'h0,1,0, 0,25'h0,1,3,0};
        vecs[24] = '{1,0,24'h0,0,24'h0,1,1, 0,25'h0,1,3,0};
        vecs[25] = '{1,1,24'h000007,0,24'h0,1,1, 0,25'h0,1,0,0};
        vecs[26] = '{1,0,24'h0,1,24'h0000AA,1,0, 0,25'h0,1,0,0};
        vecs[27] = '{1,0,24'h0,1,24'h0000BB,1,0, 0,25'h0,1,0,0};
        vecs[28] = '{1,0,24'h0,0,24'h0,0,0, 1,25'h10000BB,1,0,1};
        vecs[29] = '{1,0,24'h0,0,24'h0,0,0, 1,25'h0000007,1,0,1};
        vecs[30] = '{1,0,24'h0,0,24'h0,0,0, 0,25'h0,0,0,1};
        vecs[31] = '{0,1,24'h333333,1,24'h444444,0,0, 0,25'h0,0,0,1};
        vecs[32] = '{0,0,24'h0,0,24'h0,0,0, 0,25'h0,0,0,1};
        vecs[33] = '{1,1,24'h555555,0,24'h0,0,0, 0,25'h0,0,0,1};
        vecs[34] = '{0,1,24'h666666,0,24'h0,0,0, 1,25'h0555555,1,0,1};
        vecs[35] = '{0,0,24'h0,0,24'h0,0,0, 0,25'h0,0,0,1};

        rst_n = 1'b0;
        drive(0, 0, '0, 0, '0, 0, 0);
        #12;
        check("reset", 0, '0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].en, vecs[i].lv, vecs[i].ld, vecs[i].rv,
                  vecs[i].rd, vecs[i].full, vecs[i].clr);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].data,
                  vecs[i].busy, vecs[i].lc, vecs[i].rc);
        end

        // Fill both slots under full, overflow both, then reset mid-cycle.
        @(posedge clk); #1;
        drive(1, 1, 24'hAAAAAA, 1, 24'hBBBBBB, 1, 0);
        @(negedge clk);
        check("rst_fill", 0, '0, 0, 0, 1);
        @(posedge clk); #1;
        drive(1, 1, 24'hAAAAAA, 1, 24'hBBBBBB, 1, 0);
        @(negedge clk);
        check("rst_ovf", 0, '0, 1, 0, 1);
        @(posedge clk); #1;
        drive(1, 0, '0, 0, '0, 0, 0);
        @(negedge clk);
        check("rst_pre", 1, 25'h1BBBBBB, 1, 1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 0, '0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive(1, 0, '0, 0, '0, 0, 0);
            @(negedge clk);
            check($sformatf("rst_idle%0d", k), 0, '0, 0, 0, 0);
        end
        @(posedge clk); #1;
        drive(1, 1, 24'h000001, 1, 24'h000002, 0, 0);
        @(negedge clk);
        check("post_strobe", 0, '0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 0, '0, 0, '0, 0, 0);
        @(negedge clk);
        check("post_left", 1, 25'h0000001, 1, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_right", 1, 25'h1000002, 1, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_idle", 0, '0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
